// File: rtl/counter_game_sched.sv
// -----------------------------------------------------------------------------
// counter_game_sched
//
// Round-robin scheduler that owns the shared 8-bit game counter. Each cycle it
// grants and applies at most one requester operation (+1, +2, -1, -2). A small
// game FSM (IDLE / RUN / DONE) loads the start value. It reports a win when the
// count reaches 8'hFF and a loss when it reaches 8'h00, and records which
// requester's operation ended the game.
//
// Build option:
//   SATURATE_EN  defined   -> arithmetic clamps to 8'h00 .. 8'hFF
//                undefined -> arithmetic wraps modulo 256
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   start      load load_val and (re)start a game; wins over any request
//   load_val   starting count
//   req        per-requester request level [NREQ]
//   req_op     op of requester i at [2i+1:2i]: 00=+1 01=+2 10=-1 11=-2
//   gnt        registered one-hot; bit i = op of i applied at previous edge
//   count      current counter value
//   busy       high while in RUN
//   winner     one-cycle pulse, game ended at 8'hFF
//   loser      one-cycle pulse, game ended at 8'h00
//   result_id  requester that ended the last game, held until the next end
// -----------------------------------------------------------------------------
module counter_game_sched #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [7:0]          load_val,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   req_op,
    output logic [NREQ-1:0]     gnt,
    output logic [7:0]          count,
    output logic                busy,
    output logic                winner,
    output logic                loser,
    output logic [ID_W-1:0]     result_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [7:0]        count_reg, count_next;
    logic [ID_W-1:0]   ptr_reg, ptr_next;
    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic              winner_reg, winner_next;
    logic              loser_reg, loser_next;
    logic [ID_W-1:0]   id_reg, id_next;

    // Arbitration results
    logic              found;
    logic [ID_W-1:0]   g_idx;
    logic [7:0]        g_val;
    logic [NREQ-1:0]   g_onehot;

    // Candidate new count for every lane, computed in parallel so the
    // arbiter only has to pick one.
    logic [NREQ-1:0][7:0] lane_val;

    function automatic logic [7:0] apply_op(input logic [7:0] cur,
                                            input logic [1:0] op);
`ifdef SATURATE_EN
        logic [9:0] delta;
        logic [9:0] sum;
        case (op)
            2'b00:   delta = 10'd1;
            2'b01:   delta = 10'd2;
            2'b10:   delta = 10'h3FF;
            default: delta = 10'h3FE;
        endcase
        sum = {2'b00, cur} + delta;
        // sum spans -2..257: bit 9 marks underflow, bit 8 overflow
        if (sum[9])
            return 8'h00;
        else if (sum[8])
            return 8'hFF;
        else
            return sum[7:0];
`else
        logic [7:0] delta;
        case (op)
            2'b00:   delta = 8'h01;
            2'b01:   delta = 8'h02;
            2'b10:   delta = 8'hFF;
            default: delta = 8'hFE;
        endcase
        return cur + delta;
`endif
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign lane_val[gi] = apply_op(count_reg, req_op[2*gi+1 -: 2]);
        end
    endgenerate

    // Round-robin search: first requesting lane at or above ptr_reg, wrapping.
    always_comb begin
        found    = 1'b0;
        g_idx    = '0;
        g_val    = count_reg;
        g_onehot = '0;
        for (int off = 0; off < NREQ; off++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req[k] && (((int'(ptr_reg) + off) % NREQ) == k)) begin
                    found       = 1'b1;
                    g_idx       = ID_W'(k);
                    g_val       = lane_val[k];
                    g_onehot[k] = 1'b1;
                end
            end
        end
    end

    // Next-state / next-output logic
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        ptr_next    = ptr_reg;
        gnt_next    = '0;
        winner_next = 1'b0;
        loser_next  = 1'b0;
        id_next     = id_reg;

        if (start) begin
            // A loaded value is never judged, even 8'h00 or 8'hFF.
            count_next = load_val;
            state_next = RUN;
        end else if (state_reg == RUN && found) begin
            count_next = g_val;
            ptr_next   = ID_W'((int'(g_idx) + 1) % NREQ);
            gnt_next   = g_onehot;
            if (g_val == 8'hFF) begin
                winner_next = 1'b1;
                id_next     = g_idx;
                state_next  = DONE;
            end else if (g_val == 8'h00) begin
                loser_next  = 1'b1;
                id_next     = g_idx;
                state_next  = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            count_reg  <= 8'h01;
            ptr_reg    <= '0;
            gnt_reg    <= '0;
            winner_reg <= 1'b0;
            loser_reg  <= 1'b0;
            id_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            ptr_reg    <= ptr_next;
            gnt_reg    <= gnt_next;
            winner_reg <= winner_next;
            loser_reg  <= loser_next;
            id_reg     <= id_next;
        end
    end

    assign gnt       = gnt_reg;
    assign count     = count_reg;
    assign busy      = (state_reg == RUN);
    assign winner    = winner_reg;
    assign loser     = loser_reg;
    assign result_id = id_reg;

endmodule

// File: tb/tb_counter_game_sched.sv
// -----------------------------------------------------------------------------
// tb_counter_game_sched
//
// Self-checking bench for counter_game_sched (NREQ = 4). Each driven cycle
// pushes the expected post-edge outputs, produced by a small reference model,
// onto a scoreboard queue. The scenario task pops that entry and compares it
// with the DUT after the edge. Scenario tasks also check fixed values taken
// from the game description (grant order, final counts, attribution).
// -----------------------------------------------------------------------------
module tb_counter_game_sched;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [7:0]        load_val;
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] req_op;
    logic [NREQ-1:0]   gnt;
    logic [7:0]        count;
    logic              busy;
    logic              winner;
    logic              loser;
    logic [ID_W-1:0]   result_id;

    always #5 clk = ~clk;

    counter_game_sched #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .load_val  (load_val),
        .req       (req),
        .req_op    (req_op),
        .gnt       (gnt),
        .count     (count),
        .busy      (busy),
        .winner    (winner),
        .loser     (loser),
        .result_id (result_id)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] count;
        logic       busy;
        logic       winner;
        logic       loser;
        logic [1:0] id;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: 0 = IDLE, 1 = RUN, 2 = DONE
    int         m_state = 0;
    int         m_ptr   = 0;
    logic [7:0] m_count = 8'h01;
    logic [1:0] m_id    = 2'd0;

    function automatic logic [7:0] ref_apply(input logic [7:0] c, input logic [1:0] op);
        int d;
        int s;
        case (op)
            2'b00:   d = 1;
            2'b01:   d = 2;
            2'b10:   d = -1;
            default: d = -2;
        endcase
        s = int'(c) + d;
`ifdef SATURATE_EN
        if (s > 255) s = 255;
        if (s < 0)   s = 0;
`else
        s = (s + 256) % 256;
`endif
        return 8'(s);
    endfunction

    function automatic exp_t dut_now();
        exp_t o;
        o.gnt    = gnt;
        o.count  = count;
        o.busy   = busy;
        o.winner = winner;
        o.loser  = loser;
        o.id     = result_id;
        return o;
    endfunction

    // Drive one cycle, push the model's expectation, advance past the edge.
    task automatic drive(input logic rn, input logic st, input logic [7:0] lv,
                         input logic [3:0] rq, input logic [7:0] op);
        exp_t e;
        int   g;
        logic [7:0] nv;
        reset_n  = rn;
        start    = st;
        load_val = lv;
        req      = rq;
        req_op   = op;
        e.gnt    = 4'b0;
        e.winner = 1'b0;
        e.loser  = 1'b0;
        if (!rn) begin
            m_state = 0; m_count = 8'h01; m_ptr = 0; m_id = 2'd0;
        end else if (st) begin
            m_state = 1; m_count = lv;
        end else if (m_state == 1 && rq != 4'b0) begin
            g = -1;
            for (int off = 0; off < NREQ; off++)
                if (g < 0 && rq[(m_ptr + off) % NREQ]) g = (m_ptr + off) % NREQ;
            nv       = ref_apply(m_count, op[2*g +: 2]);
            m_count  = nv;
            m_ptr    = (g + 1) % NREQ;
            e.gnt[g] = 1'b1;
            if (nv == 8'hFF) begin
                e.winner = 1'b1; m_id = 2'(g); m_state = 2;
            end else if (nv == 8'h00) begin
                e.loser = 1'b1; m_id = 2'(g); m_state = 2;
            end
        end
        e.count = m_count;
        e.busy  = (m_state == 1);
        e.id    = m_id;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, got;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 8'h00, 4'hF, 8'h55);
            e = sb_q.pop_front(); got = dut_now();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset[%0d] got=%h expected=%h", i, got, e);
            end else $display("reset[%0d] gnt=%b count=%h busy=%b", i, gnt, count, busy);
        end
        n_checks++;
        if (count !== 8'h01 || gnt !== 4'b0 || busy !== 1'b0 || winner !== 1'b0 || loser !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values got count=%h gnt=%b busy=%b w=%b l=%b required count=01 gnt=0000 busy=0 w=0 l=0",
                     count, gnt, busy, winner, loser);
        end
    endtask

    task automatic test_round_robin();
        exp_t e, got;
        logic [3:0] seq [8];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        drive(1'b1, 1'b1, 8'h10, 4'hF, 8'h00);
        e = sb_q.pop_front(); got = dut_now();
        n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL rr_load got=%h expected=%h", got, e);
        end else $display("rr_load count=%h busy=%b", count, busy);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 8'h00, 4'hF, 8'h00);
            e = sb_q.pop_front(); got = dut_now();
            n_checks++;
            if (got !== e || gnt !== seq[i]) begin
                n_fail++;
                $display("FAIL rr[%0d] got=%h gnt=%b expected=%h gnt=%b", i, got, gnt, e, seq[i]);
            end else $display("rr[%0d] gnt=%b count=%h", i, gnt, count);
        end
        n_checks++;
        if (count !== 8'h18) begin
            n_fail++; $display("FAIL rr_final got count=%h required 18", count);
        end
    endtask

    task automatic test_win();
        exp_t e, got;
        drive(1'b1, 1'b1, 8'hFD, 4'h0, 8'h00);
        e = sb_q.pop_front(); got = dut_now();
        n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL win_load got=%h expected=%h", got, e);
        end else $display("win_load count=%h", count);
        drive(1'b1, 1'b0, 8'h00, 4'b0100, 8'h10);
        e = sb_q.pop_front(); got = dut_now();
        n_checks++;
        if (got !== e || count !== 8'hFF || winner !== 1'b1 || result_id !== 2'd2) begin
            n_fail++;
            $display("FAIL win got=%h count=%h w=%b id=%0d expected=%h count=ff w=1 id=2",
                     got, count, winner, result_id, e);
        end else $display("win gnt=%b count=%h winner=%b id=%0d", gnt, count, winner, result_id);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 8'h00, 4'hF, 8'hAA);
            e = sb_q.pop_front(); got = dut_now();
            n_checks++;
            if (got !== e || count !== 8'hFF) begin
                n_fail++; $display("FAIL win_done[%0d] got=%h expected=%h", i, got, e);
            end else $display("win_done[%0d] count=%h gnt=%b busy=%b", i, count, gnt, busy);
        end
    endtask

    task automatic test_loss_wrap();
        exp_t e, got;
        drive(1'b1, 1'b1, 8'h02, 4'h0, 8'h00);
        void'(sb_q.pop_front());
        drive(1'b1, 1'b0, 8'h00, 4'b0010, 8'h0C);
        e = sb_q.pop_front(); got = dut_now();
        n_checks++;
        if (got !== e || count !== 8'h00 || loser !== 1'b1 || result_id !== 2'd1) begin
            n_fail++;
            $display("FAIL loss got=%h count=%h l=%b id=%0d expected=%h count=00 l=1 id=1",
                     got, count, loser, result_id, e);
        end else $display("loss gnt=%b count=%h loser=%b id=%0d", gnt, count, loser, result_id);
        drive(1'b1, 1'b1, 8'hFE, 4'h0, 8'h00);
        void'(sb_q.pop_front());
        drive(1'b1, 1'b0, 8'h00, 4'b1000, 8'h40);
        e = sb_q.pop_front(); got = dut_now();
        n_checks++;
`ifdef SATURATE_EN
        if (got !== e || count !== 8'hFF || winner !== 1'b1 || result_id !== 2'd3) begin
`else
        if (got !== e || count !== 8'h00 || loser !== 1'b1 || result_id !== 2'd3) begin
`endif
            n_fail++; $display("FAIL edge_fe got=%h expected=%h", got, e);
        end else $display("edge_fe count=%h winner=%b loser=%b id=%0d", count, winner, loser, result_id);
    endtask

    task automatic test_start_priority();
        exp_t e, got;
        drive(1'b1, 1'b1, 8'h20, 4'h0, 8'h00);
        void'(sb_q.pop_front());
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 8'h00, 4'b0001, 8'h00);
            e = sb_q.pop_front(); got = dut_now();
            n_checks++;
            if (got !== e) begin
                n_fail++; $display("FAIL prio_run[%0d] got=%h expected=%h", i, got, e);
            end else $display("prio_run[%0d] gnt=%b count=%h", i, gnt, count);
        end
        drive(1'b1, 1'b1, 8'h40, 4'b0001, 8'h00);
        e = sb_q.pop_front(); got = dut_now();
        n_checks++;
        if (got !== e || count !== 8'h40 || gnt !== 4'b0) begin
            n_fail++; $display("FAIL prio_start got=%h expected=%h", got, e);
        end else $display("prio_start gnt=%b count=%h", gnt, count);
        drive(1'b1, 1'b0, 8'h00, 4'b0101, 8'h00);
        e = sb_q.pop_front(); got = dut_now();
        n_checks++;
        if (got !== e || gnt !== 4'b0100) begin
            n_fail++; $display("FAIL prio_resume got=%h gnt=%b expected=%h gnt=0100", got, gnt, e);
        end else $display("prio_resume gnt=%b count=%h", gnt, count);
    endtask

    task automatic test_mid_reset();
        exp_t e, got;
        drive(1'b1, 1'b1, 8'h7F, 4'h0, 8'h00);
        void'(sb_q.pop_front());
        drive(1'b1, 1'b0, 8'h00, 4'b0010, 8'h00);
        e = sb_q.pop_front(); got = dut_now();
        n_checks++;
        if (got !== e || count !== 8'h80) begin
            n_fail++; $display("FAIL mid_run got=%h expected=%h", got, e);
        end else $display("mid_run count=%h", count);
        drive(1'b0, 1'b0, 8'h00, 4'hF, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) drive(1'b1, 1'b0, 8'h00, 4'hF, 8'hFF);
            e = sb_q.pop_front(); got = dut_now();
            n_checks++;
            if (got !== e || count !== 8'h01 || busy !== 1'b0 || winner !== 1'b0 || loser !== 1'b0) begin
                n_fail++; $display("FAIL mid_reset[%0d] got=%h expected=%h", i, got, e);
            end else $display("mid_reset[%0d] count=%h busy=%b gnt=%b", i, count, busy, gnt);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, got;
        logic st;
        logic [7:0] lv;
        for (int i = 0; i < 60; i++) begin
            st = ($urandom_range(0, 7) == 0);
            lv = 8'($urandom_range(0, 255));
            drive(1'b1, st, lv, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            e = sb_q.pop_front(); got = dut_now();
            n_checks++;
            if (got !== e) begin
                n_fail++; $display("FAIL b2b[%0d] got=%h expected=%h", i, got, e);
            end else $display("b2b[%0d] gnt=%b count=%h busy=%b w=%b l=%b id=%0d",
                              i, gnt, count, busy, winner, loser, result_id);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        load_val = 8'h00;
        req      = 4'h0;
        req_op   = 8'h00;
        test_reset();
        test_round_robin();
        test_win();
        test_loss_wrap();
        test_start_priority();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
